// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   N-way, WIDTH-bit request merger with round-robin arbitration, a forced-select
//   mode that behaves like a legacy sel-driven mux, and one registered output stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NUM_IN*WIDTH; channel i occupies [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (combinational, at most one bit set)
//   force_en   1 = fixed select on force_sel, 0 = round-robin
//   force_sel  channel index used when force_en = 1
//   out_data   registered selected data
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  out_data/out_sel valid
//   out_ready  downstream accepts output
module rr_arb_mux #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_sel_q,    out_sel_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // Winner selection. Round-robin scans offsets 1..NUM_IN from last_grant so the
    // previous winner is considered last. A forced index >= NUM_IN matches no
    // channel and therefore produces no grant.
    always_comb begin
        int unsigned pos;
        logic [SEL_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        idx     = '0;
        if (force_en) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (force_sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_IN; k++) begin
                pos = 32'(last_grant_q) + k;
                if (pos >= NUM_IN) pos = pos - NUM_IN;
                idx = SEL_W'(pos);
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    // Data mux driven only by the registered-path index; in_data never reaches an
    // output without passing through out_data_q.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        load = ~out_valid_q | out_ready;
        xfer = load & gnt_any;
        in_ready = '0;
        if (rst_n && xfer) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                in_ready[i] = (gnt_idx == SEL_W'(i));
            end
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_data_d   = gnt_data;
            out_sel_d    = gnt_idx;
            out_valid_d  = 1'b1;
            last_grant_d = gnt_idx;
        end else if (load) begin
            // Either already empty or the held beat drained this cycle.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: default 4x32 instance plus a 3x8 instance.
module tb_rr_arb_mux;

    logic clk;
    logic rst_n;

    // 4-way, 32-bit instance
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic         a_force_en;
    logic [1:0]   a_force_sel;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;
    logic         a_out_valid, a_out_ready;

    // 3-way, 8-bit instance
    logic [23:0]  b_in_data;
    logic [2:0]   b_in_valid, b_in_ready;
    logic         b_force_en;
    logic [1:0]   b_force_sel;
    logic [7:0]   b_out_data;
    logic [1:0]   b_out_sel;
    logic         b_out_valid, b_out_ready;

    int checks = 0;
    int errors = 0;

    rr_arb_mux u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .force_en(a_force_en), .force_sel(a_force_sel),
        .out_data(a_out_data), .out_sel(a_out_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .NUM_IN(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .force_en(b_force_en), .force_sel(b_force_sel),
        .out_data(b_out_data), .out_sel(b_out_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        a_in_valid  = 4'b1111;
        a_force_en  = 1'b0;
        a_force_sel = 2'd0;
        a_out_ready = 1'b0;
        b_in_data   = {8'hA2, 8'hA1, 8'hA0};
        b_in_valid  = 3'b000;
        b_force_en  = 1'b0;
        b_force_sel = 2'd0;
        b_out_ready = 1'b1;

        // Reset: outputs cleared, in_ready suppressed even with requests pending
        #3;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data",  a_out_data, 0);
        chk("rst_out_sel",   a_out_sel, 0);
        chk("rst_in_ready",  a_in_ready, 0);
        chk("rst_b_valid",   b_out_valid, 0);

        a_in_valid = 4'b0000;
        #9 rst_n = 1'b1;
        tick(); tick();
        chk("idle_out_valid", a_out_valid, 0);
        chk("idle_in_ready",  a_in_ready, 0);

        // Round-robin fairness: 0,1,2,3,0,1 one per cycle
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), a_in_ready, 4'b0001 << (k % 4));
            tick();
            chk($sformatf("rr_sel_%0d", k),   a_out_sel, k % 4);
            chk($sformatf("rr_data_%0d", k),  a_out_data, 32'h1000_0000 + (k % 4));
            chk($sformatf("rr_valid_%0d", k), a_out_valid, 1);
        end

        // Backpressure: hold sel=1 for 3 cycles, then resume at channel 2
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", a_in_ready, 0);
            tick();
            chk("bp_sel",   a_out_sel, 1);
            chk("bp_data",  a_out_data, 32'h1000_0001);
            chk("bp_valid", a_out_valid, 1);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 4'b0100);
        tick();
        chk("bp_release_sel", a_out_sel, 2);

        // Forced mode: only channel 2 granted
        a_force_en  = 1'b1;
        a_force_sel = 2'd2;
        a_in_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("force_ready", a_in_ready, 4'b0100);
        tick();
        chk("force_data",  a_out_data, 32'hDEAD_BEEF);
        chk("force_sel",   a_out_sel, 2);
        chk("force_valid", a_out_valid, 1);

        // Forced channel idle: no grant, output drains
        a_force_sel = 2'd1;
        a_in_valid  = 4'b1101;
        #1;
        chk("force_nogrant_ready", a_in_ready, 0);
        tick();
        chk("force_drain_valid", a_out_valid, 0);
        chk("force_drain_data",  a_out_data, 32'hDEAD_BEEF);
        chk("force_drain_sel",   a_out_sel, 2);

        // Back to round-robin (last_grant=2 kept): channel 3, then sparse wrap
        a_force_en = 1'b0;
        a_in_valid = 4'b1000;
        #1;
        chk("sp_ready3", a_in_ready, 4'b1000);
        tick();
        chk("sp_sel3", a_out_sel, 3);
        a_in_valid = 4'b0100;
        #1;
        chk("sp_ready2", a_in_ready, 4'b0100);
        tick();
        chk("sp_sel2",  a_out_sel, 2);
        chk("sp_data2", a_out_data, 32'hDEAD_BEEF);
        a_in_valid = 4'b1001;
        #1;
        chk("sp_ready3b", a_in_ready, 4'b1000);
        tick();
        chk("sp_sel3b",  a_out_sel, 3);
        chk("sp_data3b", a_out_data, 32'h1000_0003);
        #1;
        chk("sp_ready0", a_in_ready, 4'b0001);
        tick();
        chk("sp_sel0",  a_out_sel, 0);
        chk("sp_data0", a_out_data, 32'h1000_0000);
        a_in_valid = 4'b0000;
        tick();
        chk("sp_empty_valid", a_out_valid, 0);
        chk("sp_empty_sel",   a_out_sel, 0);

        // Reset mid-transfer with a held beat
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b0;
        tick();
        chk("mid_sel",   a_out_sel, 1);
        chk("mid_valid", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_data",  a_out_data, 0);
        chk("mid_rst_sel",   a_out_sel, 0);
        chk("mid_rst_ready", a_in_ready, 0);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_ready", a_in_ready, 4'b0001);
        a_in_valid = 4'b0000;
        tick();

        // 3-way, 8-bit: out-of-range forced index, then wrap 2 -> 0
        b_force_en  = 1'b1;
        b_force_sel = 2'd3;
        b_in_valid  = 3'b111;
        #1;
        chk("b_oor_ready", b_in_ready, 3'b000);
        tick();
        chk("b_oor_valid", b_out_valid, 0);
        b_force_sel = 2'd2;
        #1;
        chk("b_f2_ready", b_in_ready, 3'b100);
        tick();
        chk("b_f2_sel",  b_out_sel, 2);
        chk("b_f2_data", b_out_data, 8'hA2);
        b_force_en = 1'b0;
        #1;
        chk("b_wrap_ready", b_in_ready, 3'b001);
        tick();
        chk("b_wrap_sel",   b_out_sel, 0);
        chk("b_wrap_data",  b_out_data, 8'hA0);
        chk("b_wrap_valid", b_out_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-way, WIDTH-bit selector; successor to the fixed 4:1 32-bit combinational mux.
- Adds per-input valid/ready handshakes, round-robin arbitration, a forced-select mode that reproduces legacy sel-driven muxing, and one registered output stage.
- Merges multiple datapath request sources (e.g. writeback/forwarding candidates, memory request ports) onto a single downstream consumer.

Parameters:
WIDTH, 32, data bits per channel (>=1)
NUM_IN, 4, number of input channels (>=2)
SEL_W, $clog2(NUM_IN), select/index width; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  channel i holds a request
in_ready  output  NUM_IN  channel i request accepted this cycle (combinational)
force_en  input  1  1 = fixed-select mode, 0 = round-robin mode
force_sel  input  SEL_W  channel index used when force_en=1
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  registered index of the channel that supplied out_data
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  downstream accepts output

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_IN-1, so channel 0 has top priority after reset.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards any held output. No partial state survives.
- load = ~out_valid | out_ready. The output register may take new data when it is empty or is being drained in the same cycle.
- Round-robin mode (force_en=0):
  - Search channels starting at (last_grant+1) mod NUM_IN and wrapping upward. The first with in_valid=1 wins.
- Forced mode (force_en=1):
  - The candidate is force_sel only.
  - If force_sel >= NUM_IN (non-power-of-2 NUM_IN), there is no grant.
  - Other channels' valids are ignored.
- Grant: in_ready[g]=1 only for the winning channel g and only when load=1. All other in_ready bits are 0, so at most one bit is set in any cycle.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - last_grant <= g, in both modes.
- If load=1 and no grant: out_valid <= 0 when out_ready drained the prior beat; out_data and out_sel hold.
- If load=0 (out_valid=1, out_ready=0): the output holds stable, all in_ready=0, last_grant holds.
- Simultaneous drain and fill (out_valid=1, out_ready=1, a grant present): new beat loaded and out_valid stays 1. Full throughput of one beat per cycle.
- Latency: accepted input appears on out_data on the next rising edge (1 cycle).
- in_ready depends combinationally on in_valid, force_en/force_sel and out_ready. No combinational path from in_data to any output.
- Switching force_en takes effect in the same cycle. last_grant is not reset on a mode change.
- Upstream contract (not checked): in_valid, once asserted, holds until accepted, with in_data stable.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately (async); after release with all in_valid=0 -> out_valid stays 0 and in_ready=0.
- Round-robin fairness: NUM_IN=4, all in_valid=1, in_data[i]=32'h1000_000i, out_ready=1 -> out_sel sequence 0,1,2,3,0,... one per cycle, out_data matches, exactly one in_ready bit high per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data/out_sel frozen and in_ready=0; out_ready=1 -> next beat is the next channel after the held out_sel.
- Forced mode (legacy equivalence): force_en=1, force_sel=2'b10, in_valid=4'b1111, in_data2=32'hDEAD_BEEF -> only in_ready[2]=1 and out_data=32'hDEAD_BEEF, out_sel=2 one cycle later; force_sel=1 with in_valid[1]=0 -> no grant and out_valid drops after drain.
- Sparse requests with wrap: last_grant=3, in_valid=4'b0100 -> grant 2; then in_valid=4'b1001 -> grant 3, then 0.
- Parameter sweep: WIDTH=8, NUM_IN=3, force_en=1, force_sel=3 -> no grant, in_ready=3'b000; round-robin wraps 2 -> 0.
